// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//   Consumer end of the decoded-control interface. This module takes the
//   ID-stage control bundle and carries it through the ID/EX, EX/MEM and
//   MEM/WB pipeline registers.
//   - A load-use hazard produces a one-cycle stall. EX captures a bubble
//     during that cycle.
//   - A taken branch that resolves in MEM produces a flush. EX and MEM both
//     capture bubbles.
//   - When a flush and a stall occur in the same cycle, the flush wins.
//   - Stall cycles and flush events are counted in saturating counters.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   id_*                 decoded ID-stage bundle and register indices
//   ex_cond              branch condition for the instruction now in EX
//   ex_*                 EX-stage control (registered)
//   mem_*                MEM-stage control (registered)
//   wb_*                 WB-stage control (registered)
//   stall                hold PC and IF/ID this cycle (combinational)
//   flush                squash IF/ID this cycle (combinational)
//   stall_cnt/flush_cnt  saturating performance counters (registered)
// ---------------------------------------------------------------------------
module ctrl_pipe #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [1:0]       id_aluop,
   input  logic             id_alusrc,
   input  logic             id_mtor,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             id_memwrite,
   input  logic             id_branch,
   input  logic [REG_W-1:0] id_rd,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             ex_cond,
   output logic             ex_valid,
   output logic [1:0]       ex_aluop,
   output logic             ex_alusrc,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_branch,
   output logic [REG_W-1:0] ex_rd,
   output logic             mem_valid,
   output logic             mem_memread,
   output logic             mem_memwrite,
   output logic [REG_W-1:0] mem_rd,
   output logic             wb_valid,
   output logic             wb_regwrite,
   output logic             wb_mtor,
   output logic [REG_W-1:0] wb_rd,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic             valid;
      logic [1:0]       aluop;
      logic             alusrc;
      logic             mtor;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             branch;
      logic [REG_W-1:0] rd;
   } ex_stage_t;

   typedef struct packed {
      logic             valid;
      logic             mtor;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             branch;
      logic             cond;
      logic [REG_W-1:0] rd;
   } mem_stage_t;

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic             mtor;
      logic [REG_W-1:0] rd;
   } wb_stage_t;

   localparam ex_stage_t  EX_BUBBLE  = '0;
   localparam mem_stage_t MEM_BUBBLE = '0;
   localparam logic [REG_W-1:0] RD_ZERO  = {REG_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   ex_stage_t  ex_q,  ex_d;
   mem_stage_t mem_q, mem_d;
   wb_stage_t  wb_q,  wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic rs1_used_s;
   logic rs2_used_s;
   logic stall_s;
   logic flush_s;

   // Hazard detection: load-use stall and taken-branch flush. Flush wins.
   always_comb begin
      rs1_used_s = id_regwrite | id_memread | id_memwrite | id_branch;
      // With alusrc=1 the second ALU operand is an immediate, so rs2 is not read.
      rs2_used_s = id_memwrite | id_branch | (id_regwrite & ~id_alusrc);
      flush_s    = mem_q.valid & mem_q.branch & mem_q.cond;
      stall_s    = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != RD_ZERO) &
                   ((rs1_used_s & (ex_q.rd == id_rs1)) |
                    (rs2_used_s & (ex_q.rd == id_rs2))) & ~flush_s;
   end

   // Next-state for the three pipeline registers and the counters.
   always_comb begin
      ex_d        = EX_BUBBLE;
      mem_d       = MEM_BUBBLE;
      wb_d        = '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                      mtor: mem_q.mtor, rd: mem_q.rd};
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (id_valid & ~stall_s & ~flush_s) begin
         ex_d.valid    = 1'b1;
         ex_d.aluop    = id_aluop;
         ex_d.alusrc   = id_alusrc;
         ex_d.mtor     = id_mtor;
         // x0 is never written, so regwrite is dropped at capture.
         ex_d.regwrite = id_regwrite & (id_rd != RD_ZERO);
         ex_d.memread  = id_memread;
         ex_d.memwrite = id_memwrite;
         ex_d.branch   = id_branch;
         ex_d.rd       = id_rd;
      end else begin
         ex_d = EX_BUBBLE;
      end

      if (flush_s) begin
         mem_d = MEM_BUBBLE;
      end else begin
         mem_d.valid    = ex_q.valid;
         mem_d.mtor     = ex_q.mtor;
         mem_d.regwrite = ex_q.regwrite;
         mem_d.memread  = ex_q.memread;
         mem_d.memwrite = ex_q.memwrite;
         mem_d.branch   = ex_q.branch;
         // Gating keeps bubbles all-zero even when ex_cond is stray.
         mem_d.cond     = ex_cond & ex_q.valid & ex_q.branch;
         mem_d.rd       = ex_q.rd;
      end

      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end

      if (flush_s && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Pipeline and counter registers; reset discards every in-flight slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= EX_BUBBLE;
         mem_q       <= MEM_BUBBLE;
         wb_q        <= '0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_aluop     = ex_q.aluop;
   assign ex_alusrc    = ex_q.alusrc;
   assign ex_memread   = ex_q.memread;
   assign ex_memwrite  = ex_q.memwrite;
   assign ex_branch    = ex_q.branch;
   assign ex_rd        = ex_q.rd;
   assign mem_valid    = mem_q.valid;
   assign mem_memread  = mem_q.memread;
   assign mem_memwrite = mem_q.memwrite;
   assign mem_rd       = mem_q.rd;
   assign wb_valid     = wb_q.valid;
   assign wb_regwrite  = wb_q.regwrite;
   assign wb_mtor      = wb_q.mtor;
   assign wb_rd        = wb_q.rd;
   assign stall        = stall_s;
   assign flush        = flush_s;
   assign stall_cnt    = stall_cnt_q;
   assign flush_cnt    = flush_cnt_q;

endmodule
